quad_step_decoder: RTL and testbench

//  Drive end of the up/down counter interface: turns raw quadrature inputs
//  (quad_a, quad_b) into the enable/direction controls the counter consumes.

---
 rtl/quad_step_decoder.sv | 152 +++++++++++++++
 tb/tb_quad_step_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature front end for an up/down counter.
// Raw A/B pins are synchronised and glitch-filtered. Gray-code steps are
// decoded x4 into enable/direction pulses. Illegal double-bit transitions
// are flagged. A reference position count is kept.
//
// Output contract: enable is a one-cycle strobe. direction is meaningful
// whenever enable=1 and otherwise keeps its last value. illegal is a
// one-cycle strobe. enable and illegal are never high in the same cycle.
// err stays set until rst. o_dbg_state shows the FSM state (0=INIT, 1=TRACK).
module quad_step_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  output logic             enable,
  output logic             direction,
  output logic             illegal,
  output logic             err,
  output logic [WIDTH-1:0] position,
  output logic             o_dbg_state
);

  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int IW = $clog2(FILTER_LEN + 3);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILTER_LEN + 1);

  // Bit 1 carries channel A and bit 0 carries channel B throughout.
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_init_cnt;
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_filt;
  logic [CW-1:0]   r_cnt [2];
  logic [1:0]      r_prev;
  logic            w_init;
  logic            w_track;
  logic            w_up;
  logic            w_dn;
  logic            w_both;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state: INIT lasts FILTER_LEN+2 cycles. This is long enough for the
  // synchroniser to settle before decoding starts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_init_cnt == INIT_LAST) w_state_nxt = ST_TRACK;
      ST_TRACK: w_state_nxt = ST_TRACK;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: phase qualifiers used by the datapath.
  always_comb begin
    w_init      = (r_state == ST_INIT);
    w_track     = (r_state == ST_TRACK);
    o_dbg_state = r_state;
  end

  // Count the cycles spent in INIT since reset was released.
  always_ff @(posedge clk) begin
    if (rst || !w_init)             r_init_cnt <= '0;
    else if (r_init_cnt != INIT_LAST) r_init_cnt <= r_init_cnt + IW'(1);
  end

  // Two-flop synchroniser for both channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {quad_a, quad_b};
      r_sync <= r_meta;
    end
  end

  // Per-channel filter. The filtered bit follows the synced bit only after
  // FILTER_LEN consecutive disagreeing cycles. During INIT it tracks directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_init) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else if (r_sync[i] == r_filt[i]) begin
          r_cnt[i]  <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i]  <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Gray-code decode of previous vs current filtered pair.
  // The up sequence is 00->10->11->01->00.
  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    case ({r_prev, r_filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_dn = 1'b1;
      default: ;
    endcase
    w_both = ((r_prev ^ r_filt) == 2'b11);
  end

  // Previous-state register. In INIT it is seeded from the synced pins, so
  // the level present at reset release never looks like a step.
  always_ff @(posedge clk) begin
    if (rst)         r_prev <= 2'b00;
    else if (w_init) r_prev <= r_sync;
    else             r_prev <= r_filt;
  end

  // Registered step/illegal strobes, sticky error and position count.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= 1'b0;
      direction <= 1'b0;
      illegal   <= 1'b0;
      err       <= 1'b0;
      position  <= '0;
    end else begin
      enable  <= w_track && (w_up || w_dn);
      illegal <= w_track && w_both;
      if (w_track && w_both) err <= 1'b1;
      if (w_track && (w_up || w_dn)) begin
        direction <= w_up;
        position  <= w_up ? position + WIDTH'(1) : position - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILTER_LEN=3 and WIDTH=8.
// Expected values are computed by hand. Inputs change on the falling edge.
// Outputs are sampled 1ns after the rising edge.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       enable;
  logic       direction;
  logic       illegal;
  logic       err;
  logic [7:0] position;
  logic       dbg_state;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int tot_en   = 0;
  int tot_ill  = 0;
  int tot_both = 0;

  quad_step_decoder #(.FILTER_LEN(3), .WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .quad_a      (quad_a),
    .quad_b      (quad_b),
    .enable      (enable),
    .direction   (direction),
    .illegal     (illegal),
    .err         (err),
    .position    (position),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts the cycles in which each strobe is high.
  always @(posedge clk) begin
    #1;
    if (enable === 1'b1) tot_en++;
    if (illegal === 1'b1) tot_ill++;
    if (enable === 1'b1 && illegal === 1'b1) tot_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold rst high for two edges, then check the reset values and release rst.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_enable", enable, 0);
    check("rst_illegal", illegal, 0);
    check("rst_err", err, 0);
    check("rst_position", position, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
  endtask

  // Apply a new AB level and hold it. Count enable pulses in the hold window
  // and record the latency of the first pulse, measured from the input change.
  task automatic drive_ab(input logic a, input logic b, input int hold,
                          output int n_en, output int lat);
    int t0;
    @(negedge clk);
    quad_a = a;
    quad_b = b;
    t0   = cyc;
    n_en = 0;
    lat  = -1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (enable === 1'b1) begin
        n_en++;
        if (lat < 0) lat = cyc - t0;
      end
    end
  endtask

  // One legal step: expect one pulse, 6 cycles of latency, and the given
  // direction and position.
  task automatic step(input string tag, input logic a, input logic b,
                      input logic exp_dir, input logic [7:0] exp_pos);
    int n, lat;
    drive_ab(a, b, 12, n, lat);
    check({tag, "_pulses"}, n, 1);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_dir"}, direction, exp_dir);
    check({tag, "_pos"}, position, exp_pos);
  endtask

  initial begin
    int n, lat, en0, ill0;

    // 1. Reset with A=B=0, then idle for 20 cycles.
    do_reset();
    repeat (20) @(negedge clk);
    check("idle_en_pulses", tot_en, 0);
    check("idle_ill_pulses", tot_ill, 0);
    check("idle_position", position, 0);
    check("idle_direction", direction, 0);
    check("idle_err", err, 0);
    check("idle_state_track", dbg_state, 1);

    // 2. Up sequence 00->10->11->01->00.
    step("up1", 1'b1, 1'b0, 1'b1, 8'd1);
    step("up2", 1'b1, 1'b1, 1'b1, 8'd2);
    step("up3", 1'b0, 1'b1, 1'b1, 8'd3);
    step("up4", 1'b0, 1'b0, 1'b1, 8'd4);

    // 3. Down sequence 00->01->11->10->00, then one more step that wraps below 0.
    step("dn1", 1'b0, 1'b1, 1'b0, 8'd3);
    step("dn2", 1'b1, 1'b1, 1'b0, 8'd2);
    step("dn3", 1'b1, 1'b0, 1'b0, 8'd1);
    step("dn4", 1'b0, 1'b0, 1'b0, 8'd0);
    step("wrap", 1'b0, 1'b1, 1'b0, 8'd255);
    step("unwrap", 1'b0, 1'b0, 1'b1, 8'd0);

    // 4. A two-cycle glitch on A is discarded.
    en0  = tot_en;
    ill0 = tot_ill;
    @(negedge clk);
    quad_a = 1'b1;
    repeat (2) @(negedge clk);
    quad_a = 1'b0;
    repeat (14) @(negedge clk);
    check("glitch_en", tot_en - en0, 0);
    check("glitch_ill", tot_ill - ill0, 0);
    check("glitch_pos", position, 0);

    // 5. Illegal jump 00->11: one illegal cycle and a sticky err.
    ill0 = tot_ill;
    drive_ab(1'b1, 1'b1, 12, n, lat);
    check("ill_en", n, 0);
    check("ill_pulse_cycles", tot_ill - ill0, 1);
    check("ill_err", err, 1);
    check("ill_pos", position, 0);
    check("ill_dir_hold", direction, 1);
    repeat (12) @(negedge clk);
    check("ill_err_sticky", err, 1);
    do_reset();
    check("ill_err_cleared", err, 0);

    // 6. With AB=11 held, reset mid-run; then take one up step 11->01.
    en0 = tot_en;
    repeat (15) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    check("rst11_no_step", tot_en - en0, 0);
    check("rst11_pos", position, 0);
    check("rst11_state", dbg_state, 1);
    step("post_rst", 1'b0, 1'b1, 1'b1, 8'd1);

    check("never_en_and_ill", tot_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Backstop: end the run even if the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected finish", cyc);
    $fatal(1);
  end

endmodule
